// File: rtl/if_id_pipe_if.sv
// Fetch/decode bundle for the IF/ID pipeline register: fetch bus, SRAM word,
// stall/flush controls and the decode-side outputs.
interface if_id_pipe_if;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned BUS_W  = 2 * XLEN + 1;

  logic [BUS_W-1:0] if_bus;
  logic [ILEN-1:0]  inst_rdata;
  logic             stall;
  logic             flush;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_next_pc;
  logic [ILEN-1:0]  id_inst;

  modport master (
    output if_bus, inst_rdata, stall, flush,
    input  id_valid, id_pc, id_next_pc, id_inst
  );

  modport slave (
    input  if_bus, inst_rdata, stall, flush,
    output id_valid, id_pc, id_next_pc, id_inst
  );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: latches the fetch bus, pairs it with the one-cycle-late
// SRAM word, holds that word across decode stalls, and counts instructions/bubbles.
module if_id_pipe #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  if_id_pipe_if.slave      pipe,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic {RUN, HOLD} state_e;

  state_e          state;
  logic            v_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] npc_r;
  logic [ILEN-1:0] hold_inst;

  logic            bus_ce;
  logic [XLEN-1:0] bus_pc;
  logic [XLEN-1:0] bus_npc;

  assign bus_ce  = pipe.if_bus[128];
  assign bus_pc  = pipe.if_bus[127:64];
  assign bus_npc = pipe.if_bus[63:0];

  // Stage registers and hold FSM; the SRAM word is captured at the end of the
  // first stall cycle because fetch has already moved its address on.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r       <= 1'b0;
      pc_r      <= '0;
      npc_r     <= '0;
      hold_inst <= '0;
      state     <= RUN;
    end else if (pipe.flush) begin
      v_r   <= 1'b0;
      pc_r  <= bus_pc;
      npc_r <= bus_npc;
      state <= RUN;
    end else if (pipe.stall) begin
      if (state == RUN && v_r) begin
        hold_inst <= pipe.inst_rdata;
        state     <= HOLD;
      end
    end else begin
      v_r   <= bus_ce;
      pc_r  <= bus_pc;
      npc_r <= bus_npc;
      state <= RUN;
    end
  end

  // Performance counters; a flush edge counts as neither delivery nor bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_cnt   <= '0;
      bubble_cnt <= '0;
    end else if (!pipe.flush && !pipe.stall) begin
      if (v_r) inst_cnt   <= inst_cnt + CNT_W'(1);
      else     bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    pipe.id_inst = NOP_INST;
    if (v_r) pipe.id_inst = (state == HOLD) ? hold_inst : pipe.inst_rdata;
  end

  assign pipe.id_valid   = v_r;
  assign pipe.id_pc      = pc_r;
  assign pipe.id_next_pc = npc_r;

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Pipeline register between the fetch stage and the decode stage of the 64-bit in-order core. It latches the fetch bus (valid, PC, next PC) and pairs it with the instruction word returned one cycle later by the synchronous instruction SRAM. A hold buffer keeps that word stable while decode is stalled. Branch flushes squash the latched instruction, and two counters record delivered instructions and bubbles.

## Interface

Parameters:
- NOP_INST, 32'h0000_0013, word driven on id_inst whenever id_valid=0 (addi x0,x0,0)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_bus  in  129  fetch bus {ce[128], pc[127:64], next_pc[63:0]}
- inst_rdata  in  32  I-SRAM read data; returns the word for the address presented in the previous cycle
- stall  in  1  decode stall; hold all stage state
- flush  in  1  branch taken; kill the instruction in this stage
- id_valid  out  1  stage holds a live instruction
- id_pc  out  64  PC of the held instruction
- id_next_pc  out  64  fetch's next-PC for the held instruction
- id_inst  out  32  instruction word
- inst_cnt  out  CNT_W  count of instructions delivered to decode
- bubble_cnt  out  CNT_W  count of cycles with id_valid=0 and stall=0

## Operation

- Stage registers: v_r, pc_r, npc_r. Hold buffer: hold_inst[31:0]. Two-state FSM: RUN, HOLD.
- Update priority, evaluated per edge: rst > flush > stall > advance.
  - rst: v_r=0, pc_r=0, npc_r=0, hold_inst=0, state=RUN, both counters=0.
  - flush: v_r=0, state=RUN. pc_r and npc_r are don't-care and are loaded from if_bus. The hold buffer is dropped.
  - stall and not flush: v_r, pc_r and npc_r keep their values.
    - In RUN with v_r=1: hold_inst<=inst_rdata, state becomes HOLD.
    - In RUN with v_r=0: state stays RUN.
    - In HOLD: hold_inst keeps its value.
  - advance (no stall, no flush): v_r<=if_bus[128], pc_r<=if_bus[127:64], npc_r<=if_bus[63:0], state=RUN.
- Output mux:
  - id_inst = NOP_INST when v_r=0.
  - Otherwise id_inst = hold_inst in HOLD, inst_rdata in RUN.
  - id_valid=v_r, id_pc=pc_r, id_next_pc=npc_r.
- Counters, updated on an edge only when rst=0 and flush=0:
  - inst_cnt increments on an edge where v_r=1 and stall=0.
  - bubble_cnt increments on an edge where v_r=0 and stall=0.
  - Both wrap modulo 2^CNT_W with no saturation.
- Flush has priority over stall. A flush during HOLD discards hold_inst and returns the FSM to RUN on the same edge.

## Timing

- Latency: the fetch bus sampled at edge N appears on id_pc and id_valid after edge N. id_inst in that cycle is inst_rdata, combinational from the SRAM and registered by the SRAM itself.
- During a stall, fetch also holds its PC, so inst_rdata then reflects the next PC, not pc_r. This is why the word is captured at the end of the first stall cycle.
  - First stall cycle: output comes from inst_rdata.
  - Later stall cycles: output comes from hold_inst.
- Release: on the first edge with stall=0 the stage advances. id_inst returns to inst_rdata, which now carries the word for the newly latched PC.
- Flush costs exactly one bubble. The instruction latched on the flush edge is squashed (id_valid=0 for one cycle). The branch target is then latched on the next edge.
- Reset: all outputs 0, except id_inst=NOP_INST.
- rst asserted mid-stall or mid-HOLD: reset values apply at the next edge, irrespective of stall and flush.

## Test plan

- Reset then stream: rst for 2 cycles, then if_bus ce=1 with pc 0x8000_0000, 0x8000_0004, ...; inst_rdata a one-cycle-late word sequence. Expect id_inst tracking inst_rdata, id_valid=1 from the first post-reset advance, and inst_cnt incrementing by 1 per cycle.
- 3-cycle stall: stall high while pc_r=0x8000_0008 and inst_rdata=0x00A00093, then inst_rdata changes to 0xDEADBEEF. Expect id_inst=0x00A00093 in all 3 stall cycles, pc_r unchanged, inst_cnt frozen, and RUN resuming after release.
- Flush: flush=1 for 1 cycle while streaming. Expect id_valid=0 and id_inst=0x00000013 for exactly one cycle, bubble_cnt+1, then the target PC latched.
- Flush during HOLD (stall=1, flush=1): expect the FSM to return to RUN, id_valid=0, and the hold word never to reappear.
- ce=0 on if_bus for 4 cycles: expect id_valid=0 and bubble_cnt+4.
- Counter wrap: force inst_cnt to 2^CNT_W-1 and deliver one instruction. Expect inst_cnt=0.
